// File: rtl/instruction_fetch_pkg.sv
// Shared CPU types: fetch FSM states, fetch buffer entry, word sizes.
package cpu_types;
  localparam int          XLEN    = 32;
  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, FLUSH} fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  // Word-align an address by clearing the two low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch bus: instruction-memory side and decode-stage side.
interface instruction_fetch_if;
  import cpu_types::*;
  logic               mem_req;
  logic [XLEN-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic [XLEN-1:0]    instr_pc;
  logic               instr_ready;
  logic               redirect;
  logic [XLEN-1:0]    redirect_target;

  modport master (
    output mem_req, mem_addr, instr_valid, instruction, instr_pc,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_target
  );
  modport slave (
    input  mem_req, mem_addr, instr_valid, instruction, instr_pc,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_target
  );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// 2-entry fetch FIFO; head is shown combinationally from storage.
module instruction_buffer
  import cpu_types::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);
  fetch_entry_t r_mem [2];
  logic         r_rd, r_wr;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;

  // Flush wins over both push and pop; a push into a full FIFO needs a same-cycle pop.
  assign w_pop   = i_pop  & ~i_flush & ~o_empty;
  assign w_push  = i_push & ~i_flush & (~o_full | w_pop);
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_head  = r_mem[r_rd];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '{instr: '0, pc: RESET_PC};
      r_mem[1] <= '{instr: '0, pc: RESET_PC};
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_rd  <= r_wr;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding memory requester feeding a 2-entry buffer.
module instruction_fetch
  import cpu_types::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);
  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_mem_req;
  logic [XLEN-1:0] r_mem_addr;

  logic            w_full, w_empty, w_pop, w_push, w_reissue;
  logic [XLEN-1:0] w_next_pc;
  fetch_entry_t    w_head, w_wdata;

  assign w_pop     = ~w_empty & bus.instr_ready;
  assign w_push    = (r_state == WAIT_ACK) & bus.mem_ack & ~bus.redirect;
  assign w_wdata   = '{instr: bus.mem_rdata, pc: r_mem_addr};
  assign w_next_pc = r_fetch_pc + PC_INC;
  // After this push (and any pop) a slot is still free: request the next word now.
  assign w_reissue = w_empty | (w_pop & ~w_full);

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr_valid = ~w_empty;
  assign bus.instruction = w_head.instr;
  assign bus.instr_pc    = w_head.pc;

  instruction_buffer #(.RESET_PC(RESET_PC)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Fetch FSM with registered request outputs; redirect always retargets fetch_pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.redirect) begin
            r_fetch_pc <= align_pc(bus.redirect_target);
          end else if (!w_full) begin
            r_state    <= WAIT_ACK;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        WAIT_ACK: begin
          if (bus.redirect) begin
            r_fetch_pc <= align_pc(bus.redirect_target);
            if (bus.mem_ack) begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
            end else begin
              r_state <= FLUSH;
            end
          end else if (bus.mem_ack) begin
            r_fetch_pc <= w_next_pc;
            if (w_reissue) begin
              r_mem_addr <= w_next_pc;
            end else begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (bus.redirect) r_fetch_pc <= align_pc(bus.redirect_target);
          if (bus.mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle table plus randomized stream check.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  instruction_fetch_if bus ();
  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ack, rdy, redir;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] dword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  function automatic vec_t mk(input logic r, a, y, d, input logic [31:0] t,
                              input logic q, input logic [31:0] ad,
                              input logic v, input logic [31:0] p);
    vec_t x;
    x.rst = r; x.ack = a; x.rdy = y; x.redir = d; x.tgt = t;
    x.e_req = q; x.e_addr = ad; x.e_vld = v; x.e_pc = p;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, a, y, d, input logic [31:0] t);
    rst                 = r;
    bus.mem_ack         = a;
    bus.instr_ready     = y;
    bus.redirect        = d;
    bus.redirect_target = t;
    bus.mem_rdata       = a ? dword(bus.mem_addr) : 32'hDEAD_BEEF;
  endtask

  initial begin
    int          wl, consumed;
    logic [31:0] exp_pc, prev_addr, tgt;
    logic        prev_req, prev_ack, prev_redir, rdy, redir, ack;

    drive(1, 0, 0, 0, 0);

    // Sequential fetch with ready held, ack after one wait cycle.
    tbl.push_back(mk(1,0,1,0,0,            0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,            1,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,            1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,            1,4,1,0));
    tbl.push_back(mk(0,0,1,0,0,            1,4,0,0));
    tbl.push_back(mk(0,1,1,0,0,            1,8,1,4));
    tbl.push_back(mk(0,0,1,0,0,            1,8,0,0));
    tbl.push_back(mk(0,1,1,0,0,            1,12,1,8));
    // Stalled decode: two words buffered, fetch stops, resumes at 8.
    tbl.push_back(mk(1,0,0,0,0,            0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,            1,4,1,0));
    tbl.push_back(mk(0,0,0,0,0,            1,4,1,0));
    tbl.push_back(mk(0,1,0,0,0,            0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,            0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,            0,0,1,0));
    tbl.push_back(mk(0,0,1,0,0,            0,0,1,4));
    tbl.push_back(mk(0,0,0,0,0,            1,8,1,4));
    tbl.push_back(mk(0,1,0,0,0,            0,0,1,4));
    // Redirect with a request outstanding; ack arrives 3 cycles later.
    tbl.push_back(mk(1,0,0,0,0,            0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h103,      1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,            0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,            1,32'h100,0,0));
    tbl.push_back(mk(0,1,0,0,0,            1,32'h104,1,32'h100));
    // Redirect coincident with ack and ready while the buffer holds a word.
    tbl.push_back(mk(0,1,1,1,32'h200,      0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,            1,32'h200,0,0));
    tbl.push_back(mk(0,1,0,0,0,            1,32'h204,1,32'h200));
    // Redirect to the top of the address space; PC wraps to 0.
    tbl.push_back(mk(0,0,1,1,32'hFFFF_FFFF,1,32'h204,0,0));
    tbl.push_back(mk(0,1,1,0,0,            0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,            1,32'hFFFF_FFFC,0,0));
    tbl.push_back(mk(0,1,1,0,0,            1,0,1,32'hFFFF_FFFC));
    tbl.push_back(mk(0,0,1,0,0,            1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,            1,4,1,0));
    tbl.push_back(mk(0,0,1,0,0,            1,4,0,0));
    // Reset mid-request, then a stale ack right after release.
    tbl.push_back(mk(1,0,1,0,0,            0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,            1,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,            1,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,            1,4,1,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].rdy, tbl[i].redir, tbl[i].tgt);
      @(posedge clk); #1;
      chk($sformatf("row%0d mem_req", i), {31'b0, bus.mem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("row%0d instr_valid", i), {31'b0, bus.instr_valid}, {31'b0, tbl[i].e_vld});
      if (tbl[i].e_req || tbl[i].rst)
        chk($sformatf("row%0d mem_addr", i), bus.mem_addr, tbl[i].e_addr);
      if (tbl[i].e_vld || tbl[i].rst) begin
        chk($sformatf("row%0d instr_pc", i), bus.instr_pc, tbl[i].e_pc);
        chk($sformatf("row%0d instruction", i), bus.instruction,
            tbl[i].rst ? 32'h0 : dword(tbl[i].e_pc));
      end
    end

    // Randomized phase: the decode stream must be the sequential word stream
    // starting at the last redirect target, with memory contents attached.
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    exp_pc = 32'h0; consumed = 0; wl = 0;
    prev_req = 0; prev_ack = 0; prev_redir = 0; prev_addr = 0;
    for (int c = 0; c < 1500; c++) begin
      if (prev_req && !prev_ack) begin
        chk("rnd req_held", {31'b0, bus.mem_req}, 32'h1);
        chk("rnd addr_held", bus.mem_addr, prev_addr);
      end
      if (prev_redir) chk("rnd flush_valid", {31'b0, bus.instr_valid}, 32'h0);
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      if (!bus.mem_req) begin
        ack = 0; wl = $urandom_range(0, 2);
      end else if (wl == 0) begin
        ack = 1; wl = $urandom_range(0, 2);
      end else begin
        ack = 0; wl--;
      end
      if (bus.instr_valid && rdy && !redir) begin
        chk("rnd instr_pc", bus.instr_pc, exp_pc);
        chk("rnd instruction", bus.instruction, dword(exp_pc));
        exp_pc += 4;
        consumed++;
      end
      if (redir) exp_pc = tgt & ~32'h3;
      prev_req = bus.mem_req; prev_ack = ack; prev_addr = bus.mem_addr; prev_redir = redir;
      drive(0, ack, rdy, redir, tgt);
      @(posedge clk); #1;
    end
    total++;
    if (consumed < 100) begin
      bad++;
      $display("FAIL rnd progress got=%0d exp>=100", consumed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
